// File: rtl/fetch_queue.sv
// Sequential-PC fetch unit feeding a DEPTH-entry {addr, ins} queue drained by decode via valid/ready.
// Optional FETCH_PERF_EN adds saturating stall/redirect event counters.
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_ins,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP_INS = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] pc_r;
  logic [PW:0]     count_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [XLEN-1:0] addr_mem_r [DEPTH];
  logic [XLEN-1:0] ins_mem_r  [DEPTH];

  logic pop_s;
  logic push_s;
  logic empty_s;
  logic full_s;

  // Handshake decode: redirect suppresses both push and pop in its cycle.
  always_comb begin
    empty_s     = (count_r == '0);
    full_s      = (count_r == DEPTH_C);
    pop_s       = ~empty_s & ins_ready & ~redirect_valid;
    push_s      = ~redirect_valid & (~full_s | pop_s);
    fetch_stall = ~redirect_valid & full_s & ~pop_s;
    ins_valid   = ~empty_s;
    rom_addr    = pc_r;
    if (empty_s) begin
      ins      = NOP_INS;
      ins_addr = '0;
    end else begin
      ins      = ins_mem_r[rd_ptr_r];
      ins_addr = addr_mem_r[rd_ptr_r];
    end
  end

  // PC, pointers and occupancy; a redirect flushes and retargets to a word-aligned PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= RESET_PC;
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else if (redirect_valid) begin
      pc_r     <= {redirect_pc[XLEN-1:2], 2'b00};
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (push_s) begin
        pc_r     <= pc_r + PC_STEP;
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        pc_r     <= pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents beyond count are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= pc_r;
      ins_mem_r[wr_ptr_r]  <= rom_ins;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters for stall and redirect cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt    <= 32'd0;
      perf_redirect_cnt <= 32'd0;
    end else begin
      if (fetch_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (redirect_valid && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end else begin
        perf_redirect_cnt <= perf_redirect_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM model returns addr+0x100; expectations are hand-derived.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_ins        (rom_ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_addr       (ins_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_stall    (fetch_stall)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  assign rom_ins = rom_addr + 32'h0000_0100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    ins_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #2;
    check_eq("rst_valid", 32'(ins_valid), 32'd0);
    check_eq("rst_ins", ins, 32'h0000_0013);
    check_eq("rst_ins_addr", ins_addr, 32'd0);
    check_eq("rst_stall", 32'(fetch_stall), 32'd0);
    check_eq("rst_rom_addr", rom_addr, 32'd0);
    #10;
    rst = 1'b1;
    #1;
    check_eq("rel_valid", 32'(ins_valid), 32'd0);

    // streaming with ready high: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("stream_valid", 32'(ins_valid), 32'd1);
      check_eq("stream_addr", ins_addr, 32'(4 * i));
      check_eq("stream_ins", ins, 32'h100 + 32'(4 * i));
      check_eq("stream_stall", 32'(fetch_stall), 32'd0);
    end

    // restart at 0, then back-pressure for 10 cycles
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    #1;
    check_eq("redir0_stall", 32'(fetch_stall), 32'd0);
    tick;
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", 32'(ins_valid), (i >= 1) ? 32'd1 : 32'd0);
      check_eq("bp_head", ins_addr, 32'd0);
      check_eq("bp_rom_addr", rom_addr, (i < 4) ? 32'(4 * i) : 32'd16);
      check_eq("bp_stall", 32'(fetch_stall), (i >= 4) ? 32'd1 : 32'd0);
      tick;
    end

    // full queue with one pop: pop+push same cycle
    ins_ready = 1'b1;
    #1;
    check_eq("fullpop_stall", 32'(fetch_stall), 32'd0);
    check_eq("fullpop_head", ins_addr, 32'd0);
    tick;
    check_eq("fullpop_next", ins_addr, 32'd4);
    check_eq("fullpop_ins", ins, 32'h104);
    check_eq("fullpop_rom", rom_addr, 32'd20);

    // redirect with ready on a valid head: no pop, flush
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check_eq("rdy_redir_stall", 32'(fetch_stall), 32'd0);
    check_eq("rdy_redir_head", ins_addr, 32'd4);
    tick;
    redirect_valid = 1'b0;
    ins_ready      = 1'b0;
    #1;
    check_eq("flush_valid", 32'(ins_valid), 32'd0);
    check_eq("flush_rom", rom_addr, 32'h40);
    check_eq("flush_ins", ins, 32'h0000_0013);
    check_eq("flush_addr", ins_addr, 32'd0);
    tick;
    check_eq("tgt_valid", 32'(ins_valid), 32'd1);
    check_eq("tgt_addr", ins_addr, 32'h40);
    check_eq("tgt_ins", ins, 32'h140);
    tick;
    tick;
    check_eq("three_rom", rom_addr, 32'h4C);

    // redirect to unaligned target while 3 entries queued
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    ins_ready      = 1'b1;
    #1;
    check_eq("r203_head", ins_addr, 32'h40);
    tick;
    redirect_valid = 1'b0;
    #1;
    check_eq("r203_valid", 32'(ins_valid), 32'd0);
    check_eq("r203_rom", rom_addr, 32'h200);
    tick;
    check_eq("r203_tvalid", 32'(ins_valid), 32'd1);
    check_eq("r203_taddr", ins_addr, 32'h200);
    check_eq("r203_tins", ins, 32'h300);
    tick;
    check_eq("r203_next", ins_addr, 32'h204);

    // back-to-back redirects: last wins, queue stays empty
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    tick;
    redirect_pc = 32'h600;
    #1;
    check_eq("b2b_valid", 32'(ins_valid), 32'd0);
    check_eq("b2b_rom1", rom_addr, 32'h500);
    tick;
    redirect_valid = 1'b0;
    #1;
    check_eq("b2b_rom2", rom_addr, 32'h600);
    check_eq("b2b_valid2", 32'(ins_valid), 32'd0);
    tick;
    check_eq("b2b_addr", ins_addr, 32'h600);

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick;
    redirect_valid = 1'b0;
    #1;
    check_eq("wrap_rom", rom_addr, 32'hFFFF_FFFC);
    tick;
    check_eq("wrap_addr", ins_addr, 32'hFFFF_FFFC);
    check_eq("wrap_ins", ins, 32'h0000_00FC);
    check_eq("wrap_rom0", rom_addr, 32'd0);
    tick;
    check_eq("wrap_next", ins_addr, 32'd0);
    check_eq("wrap_next_ins", ins, 32'h100);

`ifdef FETCH_PERF_EN
    check_eq("perf_stall", perf_stall_cnt, 32'd6);
    check_eq("perf_redir", perf_redirect_cnt, 32'd6);
`endif

    // asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(ins_valid), 32'd0);
    check_eq("arst_rom", rom_addr, 32'd0);
    check_eq("arst_ins", ins, 32'h0000_0013);
`ifdef FETCH_PERF_EN
    check_eq("arst_perf_stall", perf_stall_cnt, 32'd0);
    check_eq("arst_perf_redir", perf_redirect_cnt, 32'd0);
`endif
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
